// File: rtl/lcd_frame_rd_sched.sv
// Display-side SDRAM read scheduler: refills the LCD pixel FIFO one burst at a time per frame.
// Optional underflow monitor is built when LCD_RD_UFLOW_DET_EN is defined.
module lcd_frame_rd_sched #(
    parameter int unsigned       BURST_LEN   = 256,
    parameter int unsigned       FRAME_WORDS = 76800,
    parameter int unsigned       FIFO_DEPTH  = 1024,
    parameter int unsigned       LOW_WATER   = 512,
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BUF0_BASE   = 24'h000000,
    parameter logic [ADDR_W-1:0] BUF1_BASE   = 24'h020000,
    parameter int unsigned       FLUSH_CYC   = 4
) (
    input  logic              lcd_pclk,
    input  logic              rst_n,
    input  logic              lcd_vs,
    input  logic              wr_frame_done,
    input  logic [10:0]       fifo_level,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [8:0]        rd_len,
    input  logic              rd_done,
    output logic              fifo_flush,
    output logic              wr_buf_sel,
    output logic              disp_buf_sel,
    output logic              frame_active,
    output logic              uflow_flag,
    output logic [15:0]       uflow_cnt,
    input  logic              data_req,
    input  logic              fifo_empty
);

    localparam int unsigned N_BURST  = (FRAME_WORDS + BURST_LEN - 1) / BURST_LEN;
    localparam int unsigned BURST_SH = $clog2(BURST_LEN);
    localparam int unsigned FLUSH_W  = $clog2(FLUSH_CYC + 1);
    // Clamp so a full burst always fits once the refill threshold is crossed.
    localparam int unsigned LW_EFF   = (LOW_WATER > FIFO_DEPTH - BURST_LEN) ?
                                       (FIFO_DEPTH - BURST_LEN) : LOW_WATER;

    typedef enum logic [2:0] {StIdle, StFlush, StCheck, StReq, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic                lcd_vs_d1;
    logic                vs_rise;
    logic [15:0]         burst_cnt_q, burst_cnt_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                restart_pend_q, restart_pend_d;
    logic                wr_buf_sel_q, last_done_buf_q, ready_q, disp_buf_sel_q;
    logic                flush_entry;
    logic [ADDR_W-1:0]   buf_base, burst_off;

    assign vs_rise     = lcd_vs & ~lcd_vs_d1;
    assign flush_entry = (state_d == StFlush) && (state_q != StFlush);

    always_comb begin
        state_d        = state_q;
        burst_cnt_d    = burst_cnt_q;
        flush_cnt_d    = '0;
        restart_pend_d = restart_pend_q;
        unique case (state_q)
            StIdle: if (vs_rise) state_d = StFlush;
            StFlush: begin
                burst_cnt_d    = '0;
                restart_pend_d = 1'b0;
                flush_cnt_d    = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) state_d = StCheck;
            end
            StCheck: begin
                if (vs_rise)                              state_d = StFlush;
                else if (burst_cnt_q == 16'(N_BURST))     state_d = StDone;
                else if (fifo_level < 11'(LW_EFF))        state_d = StReq;
            end
            StReq: begin
                if (vs_rise) restart_pend_d = 1'b1;
                if (rd_ack)  state_d = StWait;
            end
            StWait: begin
                if (vs_rise) restart_pend_d = 1'b1;
                // The in-flight burst always completes before a pending restart is honoured.
                if (rd_done) begin
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    state_d     = (restart_pend_q || vs_rise) ? StFlush : StCheck;
                end
            end
            StDone: if (vs_rise) state_d = StFlush;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            lcd_vs_d1      <= 1'b0;
            burst_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            restart_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lcd_vs_d1      <= lcd_vs;
            burst_cnt_q    <= burst_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            restart_pend_q <= restart_pend_d;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_buf_sel_q    <= 1'b0;
            last_done_buf_q <= 1'b0;
            ready_q         <= 1'b0;
            disp_buf_sel_q  <= 1'b0;
        end else begin
            if (wr_frame_done) begin
                last_done_buf_q <= wr_buf_sel_q;
                wr_buf_sel_q    <= ~wr_buf_sel_q;
            end
            // A frame completing on the very cycle of FLUSH entry is taken directly.
            if (flush_entry) begin
                if (wr_frame_done)  disp_buf_sel_q <= wr_buf_sel_q;
                else if (ready_q)   disp_buf_sel_q <= last_done_buf_q;
                ready_q <= 1'b0;
            end else if (wr_frame_done) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign buf_base  = disp_buf_sel_q ? BUF1_BASE : BUF0_BASE;
    assign burst_off = ADDR_W'(burst_cnt_q) << BURST_SH;

    assign rd_req       = (state_q == StReq);
    assign rd_addr      = buf_base + burst_off;
    assign rd_len       = 9'(BURST_LEN);
    assign fifo_flush   = (state_q == StFlush);
    assign wr_buf_sel   = wr_buf_sel_q;
    assign disp_buf_sel = disp_buf_sel_q;
    assign frame_active = (state_q == StCheck) || (state_q == StReq) || (state_q == StWait);

`ifdef LCD_RD_UFLOW_DET_EN
    logic        uflow_flag_q;
    logic [15:0] uflow_cnt_q;
    logic        uflow_ev;

    assign uflow_ev = data_req & fifo_empty & frame_active;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            uflow_flag_q <= 1'b0;
            uflow_cnt_q  <= '0;
        end else if (uflow_ev) begin
            uflow_flag_q <= 1'b1;
            if (uflow_cnt_q != 16'hFFFF) uflow_cnt_q <= uflow_cnt_q + 16'd1;
        end
    end

    assign uflow_flag = uflow_flag_q;
    assign uflow_cnt  = uflow_cnt_q;
`else
    logic unused_uflow_in;
    assign unused_uflow_in = data_req ^ fifo_empty;
    assign uflow_flag      = 1'b0;
    assign uflow_cnt       = '0;
`endif

endmodule

// File: tb/tb_lcd_frame_rd_sched.sv
`timescale 1ns/1ps
// Bench for lcd_frame_rd_sched: SDRAM responder, burst-address scoreboard, ping-pong buffer model.
module tb_lcd_frame_rd_sched;

    localparam int unsigned NB        = 300;
    localparam int unsigned FLUSH_CYC = 4;
    localparam logic [23:0] BUF0      = 24'h000000;
    localparam logic [23:0] BUF1      = 24'h020000;
`ifdef LCD_RD_UFLOW_DET_EN
    localparam logic        UF_EN     = 1'b1;
`else
    localparam logic        UF_EN     = 1'b0;
`endif

    typedef struct {
        logic [10:0] level;
        logic        exp_req;
    } wm_vec_t;

    logic        lcd_pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lcd_vs = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic [10:0] fifo_level = 11'd0;
    logic        rd_ack = 1'b0;
    logic        rd_done = 1'b0;
    logic        data_req = 1'b0;
    logic        fifo_empty = 1'b0;
    logic        rd_req, fifo_flush, wr_buf_sel, disp_buf_sel, frame_active, uflow_flag;
    logic [23:0] rd_addr;
    logic [8:0]  rd_len;
    logic [15:0] uflow_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    int          ack_dly = 2;
    int          done_dly = 3;
    logic        resp_en = 1'b1;
    int          bursts_done = 0;
    logic        in_wait = 1'b0;
    int          flush_run = 0;
    int          flush_len = 0;
    int          flush_pulses = 0;
    logic        m_wr = 1'b0, m_last = 1'b0, m_ready = 1'b0, m_disp = 1'b0;
    wm_vec_t     wm_tab[8];
    logic [23:0] r_a0;
    logic        r_stable;
    logic        saw, bad;
    int          tgt, prev, n;

    lcd_frame_rd_sched dut (
        .lcd_pclk      (lcd_pclk),
        .rst_n         (rst_n),
        .lcd_vs        (lcd_vs),
        .wr_frame_done (wr_frame_done),
        .fifo_level    (fifo_level),
        .rd_req        (rd_req),
        .rd_ack        (rd_ack),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_done       (rd_done),
        .fifo_flush    (fifo_flush),
        .wr_buf_sel    (wr_buf_sel),
        .disp_buf_sel  (disp_buf_sel),
        .frame_active  (frame_active),
        .uflow_flag    (uflow_flag),
        .uflow_cnt     (uflow_cnt),
        .data_req      (data_req),
        .fifo_empty    (fifo_empty)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input logic [23:0] act);
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_addr: got 0x%0h, expected no request", act);
        end else begin
            e = exp_q.pop_front();
            check("sb_addr", 32'(act), 32'(e));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_req"},       32'(rd_req),       32'd0);
        check({tag, "_rd_addr"},      32'(rd_addr),      32'd0);
        check({tag, "_rd_len"},       32'(rd_len),       32'd256);
        check({tag, "_fifo_flush"},   32'(fifo_flush),   32'd0);
        check({tag, "_wr_buf_sel"},   32'(wr_buf_sel),   32'd0);
        check({tag, "_disp_buf_sel"}, 32'(disp_buf_sel), 32'd0);
        check({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        check({tag, "_uflow_flag"},   32'(uflow_flag),   32'd0);
        check({tag, "_uflow_cnt"},    32'(uflow_cnt),    32'd0);
    endtask

    task automatic frame_done_pulse();
        m_last = m_wr;
        m_wr = ~m_wr;
        m_ready = 1'b1;
        wr_frame_done = 1'b1;
        @(negedge lcd_pclk);
        wr_frame_done = 1'b0;
        check("wr_buf_sel", 32'(wr_buf_sel), 32'(m_wr));
    endtask

    task automatic vs_pulse(input logic with_done);
        if (with_done) begin
            m_disp = m_wr;
            m_last = m_wr;
            m_wr = ~m_wr;
            m_ready = 1'b0;
            wr_frame_done = 1'b1;
        end else if (m_ready) begin
            m_disp = m_last;
            m_ready = 1'b0;
        end
        lcd_vs = 1'b1;
        @(negedge lcd_pclk);
        wr_frame_done = 1'b0;
        @(negedge lcd_pclk);
        lcd_vs = 1'b0;
    endtask

    task automatic push_frame();
        logic [23:0] base;
        base = m_disp ? BUF1 : BUF0;
        exp_q.delete();
        for (int i = 0; i < NB; i++) exp_q.push_back(base + 24'(i * 256));
    endtask

    task automatic wait_flush(input int prev_cnt, input int budget);
        int k;
        k = 0;
        while (flush_pulses <= prev_cnt && k < budget) begin
            @(negedge lcd_pclk);
            k++;
        end
        check("flush_seen", 32'(flush_pulses > prev_cnt), 32'd1);
        check("flush_len", 32'(flush_len), FLUSH_CYC);
        check("disp_buf_sel", 32'(disp_buf_sel), 32'(m_disp));
    endtask

    task automatic start_frame(input logic with_done);
        int p;
        p = flush_pulses;
        vs_pulse(with_done);
        push_frame();
        wait_flush(p, 30);
    endtask

    task automatic wait_bursts(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (bursts_done < target && k < budget) begin
            @(negedge lcd_pclk);
            k++;
        end
        check(name, 32'(bursts_done >= target), 32'd1);
    endtask

    // SDRAM responder: acks after ack_dly cycles, signals completion done_dly cycles later.
    initial forever begin
        @(negedge lcd_pclk);
        if (resp_en && rst_n && rd_req) begin
            r_a0 = rd_addr;
            r_stable = 1'b1;
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge lcd_pclk);
                if (!rd_req || rd_addr !== r_a0) r_stable = 1'b0;
            end
            rd_ack = 1'b1;
            if (ack_dly >= 10) check("req_hold", 32'(r_stable), 32'd1);
            sb_check(rd_addr);
            @(negedge lcd_pclk);
            rd_ack = 1'b0;
            check("req_drop", 32'(rd_req), 32'd0);
            in_wait = 1'b1;
            for (int i = 0; i < done_dly; i++) @(negedge lcd_pclk);
            rd_done = 1'b1;
            in_wait = 1'b0;
            bursts_done++;
            @(negedge lcd_pclk);
            rd_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge lcd_pclk);
        if (fifo_flush) begin
            flush_run++;
        end else if (flush_run != 0) begin
            flush_len = flush_run;
            flush_run = 0;
            flush_pulses++;
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        wm_tab[0] = '{level: 11'd600,  exp_req: 1'b0};
        wm_tab[1] = '{level: 11'd1024, exp_req: 1'b0};
        wm_tab[2] = '{level: 11'd512,  exp_req: 1'b0};
        wm_tab[3] = '{level: 11'd511,  exp_req: 1'b1};
        wm_tab[4] = '{level: 11'd700,  exp_req: 1'b0};
        wm_tab[5] = '{level: 11'd0,    exp_req: 1'b1};
        wm_tab[6] = '{level: 11'd2047, exp_req: 1'b0};
        wm_tab[7] = '{level: 11'd256,  exp_req: 1'b1};

        repeat (3) @(negedge lcd_pclk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge lcd_pclk);

        // Underflow conditions outside a frame never count.
        data_req = 1'b1;
        fifo_empty = 1'b1;
        repeat (2) @(negedge lcd_pclk);
        data_req = 1'b0;
        fifo_empty = 1'b0;
        check("uflow_idle_flag", 32'(uflow_flag), 32'd0);

        // Full frame with an always-empty FIFO: 300 bursts from buffer 0.
        fifo_level = 11'd0;
        tgt = bursts_done + NB;
        start_frame(1'b0);
        check("f1_active", 32'(frame_active), 32'd1);
        wait_bursts(tgt, 6000, "f1_bursts");
        repeat (4) @(negedge lcd_pclk);
        check("f1_done_active", 32'(frame_active), 32'd0);
        check("f1_done_req", 32'(rd_req), 32'd0);
        check("f1_burst_total", 32'(bursts_done), 32'(tgt));
        check("f1_sb_left", 32'(exp_q.size()), 32'd0);

        // Frame 2 shows buffer 0's completed frame; walk the low-water table.
        frame_done_pulse();
        fifo_level = 11'd600;
        start_frame(1'b0);
        for (int i = 0; i < 8; i++) begin
            tgt = bursts_done + 1;
            fifo_level = wm_tab[i].level;
            saw = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge lcd_pclk);
                if (rd_req) saw = 1'b1;
                if (saw) break;
            end
            if (saw) fifo_level = 11'd600;
            check($sformatf("wm_req[%0d]", i), 32'(saw), 32'(wm_tab[i].exp_req));
            if (saw) wait_bursts(tgt, 100, "wm_burst");
        end

        // Slow acknowledge: request and address must hold for all 50 cycles.
        ack_dly = 50;
        tgt = bursts_done + 1;
        fifo_level = 11'd0;
        repeat (2) @(negedge lcd_pclk);
        fifo_level = 11'd600;
        wait_bursts(tgt, 200, "slow_ack_burst");
        ack_dly = 2;

        // Restart during WAIT with a fresh frame ready: no new request, then buffer 1 from base.
        done_dly = 20;
        fifo_level = 11'd0;
        n = 0;
        while (!in_wait && n < 20) begin
            @(negedge lcd_pclk);
            n++;
        end
        check("rs_in_wait", 32'(in_wait), 32'd1);
        frame_done_pulse();
        prev = flush_pulses;
        tgt = bursts_done + 1;
        vs_pulse(1'b0);
        push_frame();
        bad = 1'b0;
        n = 0;
        while (bursts_done < tgt && n < 40) begin
            @(negedge lcd_pclk);
            if (rd_req) bad = 1'b1;
            n++;
        end
        check("rs_no_req", 32'(bad), 32'd0);
        check("rs_burst_done", 32'(bursts_done >= tgt), 32'd1);
        done_dly = 3;
        wait_flush(prev, 30);
        wait_bursts(bursts_done + 2, 100, "rs_bursts");
        fifo_level = 11'd600;
        repeat (20) @(negedge lcd_pclk);

        // Writer finishes on the exact FLUSH-entry cycle: its buffer is shown at once.
        start_frame(1'b1);
        check("byp_wr_sel", 32'(wr_buf_sel), 32'(m_wr));

        // Underflow: one non-empty read, then three empty reads inside the frame.
        check("uf_active", 32'(frame_active), 32'd1);
        data_req = 1'b1;
        @(negedge lcd_pclk);
        fifo_empty = 1'b1;
        repeat (3) @(negedge lcd_pclk);
        data_req = 1'b0;
        fifo_empty = 1'b0;
        @(negedge lcd_pclk);
        check("uf_flag", 32'(uflow_flag), 32'(UF_EN));
        check("uf_cnt", 32'(uflow_cnt), UF_EN ? 32'd3 : 32'd0);

        // Reset while a request is outstanding returns everything to reset values.
        resp_en = 1'b0;
        fifo_level = 11'd0;
        n = 0;
        while (!rd_req && n < 10) begin
            @(negedge lcd_pclk);
            n++;
        end
        check("mr_req_seen", 32'(rd_req), 32'd1);
        rst_n = 1'b0;
        #2;
        check_reset("midrst");
        @(negedge lcd_pclk);
        rst_n = 1'b1;
        @(negedge lcd_pclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
